stream_mux_rr: RTL and testbench

//   Parametrised N:1 stream multiplexor with valid/ready handshake on each input
//   and one registered output. Successor to the fixed 4:1 combinational mux.

---
 rtl/stream_mux_rr.sv | 120 ++++++++++++
 tb/tb_stream_mux_rr.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N:1 valid/ready stream multiplexor with one registered output stage.
// Mode=0 passes the channel picked by Sel; Mode=1 arbitrates round-robin starting at rr_ptr.
module stream_mux_rr #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned SEL_W  = 2
) (
    input  logic                      Clk,
    input  logic                      Rst,
    input  logic [NUM_CH*WIDTH-1:0]   In_data,
    input  logic [NUM_CH-1:0]         In_valid,
    output logic [NUM_CH-1:0]         In_ready,
    input  logic                      Mode,
    input  logic [SEL_W-1:0]          Sel,
    output logic [WIDTH-1:0]          Out_data,
    output logic [SEL_W-1:0]          Out_ch,
    output logic                      Out_valid,
    input  logic                      Out_ready
);

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0] out_ch_q, out_ch_d;
    logic             out_valid_q, out_valid_d;
    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;

    logic             load_en;
    logic             grant_valid;
    logic [SEL_W-1:0] grant;
    logic [WIDTH-1:0] grant_data;
    logic             transfer;

    // Output register can take a beat when empty or being drained this cycle
    assign load_en  = !out_valid_q || Out_ready;
    assign transfer = grant_valid && load_en && !Rst;

    // Grant selection: fixed Sel, or first valid channel at/after rr_ptr with wrap
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        if (!Mode) begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                if (Sel == SEL_W'(i) && In_valid[i]) begin
                    grant       = SEL_W'(i);
                    grant_valid = 1'b1;
                end
            end
        end else begin
            // Pass 1: channels at or above the pointer, lowest first
            for (int i = 0; i < int'(NUM_CH); i++) begin
                if (!grant_valid && SEL_W'(i) >= rr_ptr_q && In_valid[i]) begin
                    grant       = SEL_W'(i);
                    grant_valid = 1'b1;
                end
            end
            // Pass 2: wrapped search from channel 0
            for (int i = 0; i < int'(NUM_CH); i++) begin
                if (!grant_valid && In_valid[i]) begin
                    grant       = SEL_W'(i);
                    grant_valid = 1'b1;
                end
            end
        end
    end

    // Data of the granted channel
    always_comb begin
        grant_data = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (grant == SEL_W'(i)) begin
                grant_data = In_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // One-hot ready toward the granted channel; suppressed while in reset
    always_comb begin
        In_ready = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            In_ready[i] = transfer && (grant == SEL_W'(i));
        end
    end

    // Next state of the output stage and round-robin pointer
    always_comb begin
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        rr_ptr_d    = rr_ptr_q;
        if (transfer) begin
            out_data_d  = grant_data;
            out_ch_d    = grant;
            out_valid_d = 1'b1;
            if (Mode) begin
                rr_ptr_d = (grant == SEL_W'(NUM_CH - 1)) ? '0 : grant + SEL_W'(1);
            end
        end else if (Out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers with synchronous reset that overrides any transfer
    always_ff @(posedge Clk) begin
        if (Rst) begin
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            rr_ptr_q    <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign Out_data  = out_data_q;
    assign Out_ch    = out_ch_q;
    assign Out_valid = out_valid_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb_stream_mux_rr: table-driven directed vectors plus random traffic against a reference model.
module tb_stream_mux_rr;

    localparam int unsigned W  = 32;
    localparam int unsigned N  = 4;
    localparam int unsigned SW = 2;

    logic            Clk = 1'b0;
    logic            Rst;
    logic [N*W-1:0]  In_data;
    logic [N-1:0]    In_valid;
    logic [N-1:0]    In_ready;
    logic            Mode;
    logic [SW-1:0]   Sel;
    logic [W-1:0]    Out_data;
    logic [SW-1:0]   Out_ch;
    logic            Out_valid;
    logic            Out_ready;

    stream_mux_rr #(.WIDTH(W), .NUM_CH(N), .SEL_W(SW)) dut (
        .Clk(Clk), .Rst(Rst), .In_data(In_data), .In_valid(In_valid), .In_ready(In_ready),
        .Mode(Mode), .Sel(Sel), .Out_data(Out_data), .Out_ch(Out_ch),
        .Out_valid(Out_valid), .Out_ready(Out_ready)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic        rst;
        logic        mode;
        logic [1:0]  sel;
        logic [3:0]  valid;
        logic        oready;
        logic        chk;       // compare against the literal expectations below
        logic [3:0]  e_ready;
        logic        e_valid;
        logic [31:0] e_data;
        logic [1:0]  e_ch;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: contents of the output stage and arbitration pointer
    int       m_valid = 0;
    int       m_data  = 0;
    int       m_ch    = 0;
    int       m_ptr   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int chan_data(input int c);
        logic [N*W-1:0] d;
        d = In_data;
        return int'(d[c*W +: W]);
    endfunction

    // Model grant: returns channel or -1 when nothing can be granted
    function automatic int model_grant(input vec_t v);
        int c;
        if (!v.mode) begin
            if (int'(v.sel) < int'(N) && v.valid[v.sel]) return int'(v.sel);
            return -1;
        end
        for (int k = 0; k < int'(N); k++) begin
            c = (m_ptr + k) % int'(N);
            if (v.valid[c]) return c;
        end
        return -1;
    endfunction

    // Drive one cycle, check ready before the edge and outputs after it
    task automatic apply(input vec_t v, input string tag);
        int g;
        int load;
        logic [3:0] m_ready;
        @(negedge Clk);
        Rst       = v.rst;
        Mode      = v.mode;
        Sel       = v.sel;
        In_valid  = v.valid;
        Out_ready = v.oready;
        #1;
        g       = model_grant(v);
        load    = (m_valid == 0 || v.oready) ? 1 : 0;
        m_ready = (!v.rst && load != 0 && g >= 0) ? 4'(1 << g) : 4'b0000;
        check({tag, " in_ready(model)"}, 32'(In_ready), 32'(m_ready));
        if (v.chk) check({tag, " in_ready"}, 32'(In_ready), 32'(v.e_ready));
        @(posedge Clk);
        if (v.rst) begin
            m_valid = 0; m_data = 0; m_ch = 0; m_ptr = 0;
        end else if (m_ready != 0) begin
            m_valid = 1; m_data = chan_data(g); m_ch = g;
            if (v.mode) m_ptr = (g + 1) % int'(N);
        end else if (v.oready) begin
            m_valid = 0;
        end
        #1;
        check({tag, " out_valid(model)"}, 32'(Out_valid), 32'(m_valid));
        check({tag, " out_data(model)"}, Out_data, 32'(m_data));
        check({tag, " out_ch(model)"}, 32'(Out_ch), 32'(m_ch));
        if (v.chk) begin
            check({tag, " out_valid"}, 32'(Out_valid), 32'(v.e_valid));
            check({tag, " out_data"}, Out_data, v.e_data);
            check({tag, " out_ch"}, 32'(Out_ch), 32'(v.e_ch));
        end
    endtask

    vec_t tab[$];
    vec_t rv;

    initial begin
        Rst = 1'b1; Mode = 1'b0; Sel = '0; In_valid = '0; Out_ready = 1'b0;
        In_data = {32'd4, 32'd3, 32'd2, 32'd1};

        // rst mode sel valid ordy chk e_ready e_valid e_data e_ch
        // Reset with every channel valid
        tab.push_back('{1, 0, 0, 4'b1111, 1, 1, 4'b0000, 0, 0, 0});
        tab.push_back('{1, 1, 0, 4'b1111, 1, 1, 4'b0000, 0, 0, 0});
        // Fixed select 0..3
        tab.push_back('{0, 0, 0, 4'b1111, 1, 1, 4'b0001, 1, 1, 0});
        tab.push_back('{0, 0, 1, 4'b1111, 1, 1, 4'b0010, 1, 2, 1});
        tab.push_back('{0, 0, 2, 4'b1111, 1, 1, 4'b0100, 1, 3, 2});
        tab.push_back('{0, 0, 3, 4'b1111, 1, 1, 4'b1000, 1, 4, 3});
        // Fixed select of an idle channel: no grant, output drains, data/ch hold
        tab.push_back('{0, 0, 2, 4'b1011, 1, 1, 4'b0000, 0, 4, 3});
        // Round-robin, all valid, 8 beats
        for (int i = 0; i < 8; i++)
            tab.push_back('{0, 1, 0, 4'b1111, 1, 1, 4'(1 << (i % 4)), 1, 32'(i % 4 + 1), 2'(i % 4)});
        // Move pointer to 2 via a ch1 grant, then only ch1/ch3 valid
        tab.push_back('{0, 1, 0, 4'b0010, 1, 1, 4'b0010, 1, 2, 1});
        tab.push_back('{0, 1, 0, 4'b1010, 1, 1, 4'b1000, 1, 4, 3});
        tab.push_back('{0, 1, 0, 4'b1010, 1, 1, 4'b0010, 1, 2, 1});
        tab.push_back('{0, 1, 0, 4'b1010, 1, 1, 4'b1000, 1, 4, 3});
        tab.push_back('{0, 1, 0, 4'b1010, 1, 1, 4'b0010, 1, 2, 1});

        foreach (tab[i]) apply(tab[i], $sformatf("vec%0d", i));

        // Backpressure: Out_data=2 held for three cycles, then drain and load ch2 same edge
        for (int i = 0; i < 3; i++)
            apply('{0, 1, 0, 4'b1111, 0, 1, 4'b0000, 1, 2, 1}, $sformatf("bp%0d", i));
        apply('{0, 1, 0, 4'b1111, 1, 1, 4'b0100, 1, 3, 2}, "bp_release");

        // Reset while holding a stalled beat, then round-robin restarts at ch0
        apply('{0, 1, 0, 4'b1111, 0, 1, 4'b0000, 1, 3, 2}, "stall");
        apply('{1, 1, 0, 4'b1111, 0, 1, 4'b0000, 0, 0, 0}, "rst_mid");
        apply('{0, 1, 0, 4'b1111, 1, 1, 4'b0001, 1, 1, 0}, "after_rst");

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            for (int c = 0; c < int'(N); c++) In_data[c*W +: W] = $urandom;
            rv.rst     = ($urandom_range(0, 39) == 0);
            rv.mode    = 1'($urandom_range(0, 1));
            rv.sel     = 2'($urandom_range(0, 3));
            rv.valid   = 4'($urandom_range(0, 15));
            rv.oready  = ($urandom_range(0, 3) != 0);
            rv.chk     = 1'b0;
            rv.e_ready = '0;
            rv.e_valid = 1'b0;
            rv.e_data  = '0;
            rv.e_ch    = '0;
            apply(rv, $sformatf("rand%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
